// File: rtl/axi4_if.sv
// AXI4 channel bundle used on both requester ports and the downstream port of the arbiter.
interface axi4_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4
);
  logic [AXI4_ID_WIDTH-1:0]      AWID;
  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR;
  logic [7:0]                    AWLEN;
  logic [2:0]                    AWSIZE;
  logic [1:0]                    AWBURST;
  logic                          AWVALID;
  logic                          AWREADY;
  logic [AXI4_DATA_WIDTH-1:0]    WDATA;
  logic [AXI4_DATA_WIDTH/8-1:0]  WSTRB;
  logic                          WLAST;
  logic                          WVALID;
  logic                          WREADY;
  logic [AXI4_ID_WIDTH-1:0]      BID;
  logic [1:0]                    BRESP;
  logic                          BVALID;
  logic                          BREADY;
  logic [AXI4_ID_WIDTH-1:0]      ARID;
  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR;
  logic [7:0]                    ARLEN;
  logic [2:0]                    ARSIZE;
  logic [1:0]                    ARBURST;
  logic                          ARVALID;
  logic                          ARREADY;
  logic [AXI4_ID_WIDTH-1:0]      RID;
  logic [AXI4_DATA_WIDTH-1:0]    RDATA;
  logic [1:0]                    RRESP;
  logic                          RLAST;
  logic                          RVALID;
  logic                          RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4_rr_arbiter.sv
// Two-requester AXI4 round-robin arbiter with independent read and write arbitration,
// one outstanding transaction per direction, zero-latency routed paths.
module axi4_rr_arbiter #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4
) (
  input  logic   clk,
  input  logic   rst,
  axi4_if.slave  m0,
  axi4_if.slave  m1,
  axi4_if.master s
);
  localparam int AX_W = AXI4_ID_WIDTH + AXI4_ADDRESS_WIDTH + 8 + 3 + 2;
  localparam int W_W  = AXI4_DATA_WIDTH + AXI4_DATA_WIDTH / 8 + 1;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_ADDR = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;
  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_XFER = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  logic [1:0] rd_state_reg, rd_state_next;
  logic       rd_grant_reg, rd_grant_next;
  logic       rd_prio_reg, rd_prio_next;
  logic [1:0] wr_state_reg, wr_state_next;
  logic       wr_grant_reg, wr_grant_next;
  logic       wr_prio_reg, wr_prio_next;
  logic       aw_done_reg, aw_done_next;
  logic       w_done_reg, w_done_next;

  // Per-requester views, indexed by the grant bit (0 = m0, 1 = m1)
  logic [AX_W-1:0] ar_bus [2];
  logic [AX_W-1:0] aw_bus [2];
  logic [W_W-1:0]  w_bus  [2];
  logic [1:0]      ar_valid, aw_valid, w_valid, r_ready, b_ready;

  assign ar_bus[0] = {m0.ARID, m0.ARADDR, m0.ARLEN, m0.ARSIZE, m0.ARBURST};
  assign ar_bus[1] = {m1.ARID, m1.ARADDR, m1.ARLEN, m1.ARSIZE, m1.ARBURST};
  assign aw_bus[0] = {m0.AWID, m0.AWADDR, m0.AWLEN, m0.AWSIZE, m0.AWBURST};
  assign aw_bus[1] = {m1.AWID, m1.AWADDR, m1.AWLEN, m1.AWSIZE, m1.AWBURST};
  assign w_bus[0]  = {m0.WDATA, m0.WSTRB, m0.WLAST};
  assign w_bus[1]  = {m1.WDATA, m1.WSTRB, m1.WLAST};
  assign ar_valid  = {m1.ARVALID, m0.ARVALID};
  assign aw_valid  = {m1.AWVALID, m0.AWVALID};
  assign w_valid   = {m1.WVALID, m0.WVALID};
  assign r_ready   = {m1.RREADY, m0.RREADY};
  assign b_ready   = {m1.BREADY, m0.BREADY};

  logic rd_addr_phase, rd_data_phase, aw_route, w_route, b_route;
  logic aw_hs, w_last_hs;

  assign rd_addr_phase = (rd_state_reg == RD_ADDR);
  assign rd_data_phase = (rd_state_reg == RD_DATA);
  assign aw_route      = (wr_state_reg == WR_XFER) && !aw_done_reg;
  assign w_route       = (wr_state_reg == WR_XFER) && !w_done_reg;
  assign b_route       = (wr_state_reg == WR_RESP);

  // Read address / data routing
  assign {s.ARID, s.ARADDR, s.ARLEN, s.ARSIZE, s.ARBURST} = ar_bus[rd_grant_reg];
  assign s.ARVALID  = rd_addr_phase && ar_valid[rd_grant_reg];
  assign m0.ARREADY = rd_addr_phase && !rd_grant_reg && s.ARREADY;
  assign m1.ARREADY = rd_addr_phase &&  rd_grant_reg && s.ARREADY;

  assign m0.RID   = s.RID;
  assign m0.RDATA = s.RDATA;
  assign m0.RRESP = s.RRESP;
  assign m0.RLAST = s.RLAST;
  assign m1.RID   = s.RID;
  assign m1.RDATA = s.RDATA;
  assign m1.RRESP = s.RRESP;
  assign m1.RLAST = s.RLAST;
  assign m0.RVALID = rd_data_phase && !rd_grant_reg && s.RVALID;
  assign m1.RVALID = rd_data_phase &&  rd_grant_reg && s.RVALID;
  assign s.RREADY  = rd_data_phase && r_ready[rd_grant_reg];

  // Write address / data / response routing; AW and W are gated independently
  assign {s.AWID, s.AWADDR, s.AWLEN, s.AWSIZE, s.AWBURST} = aw_bus[wr_grant_reg];
  assign s.AWVALID  = aw_route && aw_valid[wr_grant_reg];
  assign m0.AWREADY = aw_route && !wr_grant_reg && s.AWREADY;
  assign m1.AWREADY = aw_route &&  wr_grant_reg && s.AWREADY;

  assign {s.WDATA, s.WSTRB, s.WLAST} = w_bus[wr_grant_reg];
  assign s.WVALID  = w_route && w_valid[wr_grant_reg];
  assign m0.WREADY = w_route && !wr_grant_reg && s.WREADY;
  assign m1.WREADY = w_route &&  wr_grant_reg && s.WREADY;

  assign m0.BID   = s.BID;
  assign m0.BRESP = s.BRESP;
  assign m1.BID   = s.BID;
  assign m1.BRESP = s.BRESP;
  assign m0.BVALID = b_route && !wr_grant_reg && s.BVALID;
  assign m1.BVALID = b_route &&  wr_grant_reg && s.BVALID;
  assign s.BREADY  = b_route && b_ready[wr_grant_reg];

  assign aw_hs     = s.AWVALID && s.AWREADY;
  assign w_last_hs = s.WVALID && s.WREADY && s.WLAST;

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_grant_next = rd_grant_reg;
    rd_prio_next  = rd_prio_reg;
    case (rd_state_reg)
      RD_IDLE: begin
        if (ar_valid != 2'b00) begin
          rd_grant_next = (ar_valid == 2'b11) ? rd_prio_reg : ar_valid[1];
          rd_state_next = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (s.ARVALID && s.ARREADY) rd_state_next = RD_DATA;
      end
      RD_DATA: begin
        if (s.RVALID && s.RREADY && s.RLAST) begin
          rd_state_next = RD_IDLE;
          rd_prio_next  = ~rd_grant_reg;
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_grant_next = wr_grant_reg;
    wr_prio_next  = wr_prio_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    case (wr_state_reg)
      WR_IDLE: begin
        if (aw_valid != 2'b00) begin
          wr_grant_next = (aw_valid == 2'b11) ? wr_prio_reg : aw_valid[1];
          wr_state_next = WR_XFER;
        end
      end
      WR_XFER: begin
        // Both flags may complete on the same edge
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg | w_last_hs;
        if (aw_done_next && w_done_next) wr_state_next = WR_RESP;
      end
      WR_RESP: begin
        if (s.BVALID && s.BREADY) begin
          wr_state_next = WR_IDLE;
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
          wr_prio_next  = ~wr_grant_reg;
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg <= RD_IDLE;
      rd_grant_reg <= 1'b0;
      rd_prio_reg  <= 1'b0;
      wr_state_reg <= WR_IDLE;
      wr_grant_reg <= 1'b0;
      wr_prio_reg  <= 1'b0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_grant_reg <= rd_grant_next;
      rd_prio_reg  <= rd_prio_next;
      wr_state_reg <= wr_state_next;
      wr_grant_reg <= wr_grant_next;
      wr_prio_reg  <= wr_prio_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
    end
  end
endmodule

// File: tb/tb_axi4_rr_arbiter.sv
// Scoreboard bench for axi4_rr_arbiter: two behavioural masters and one behavioural slave.
module tb_axi4_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axi4_if m_if [2] ();
  axi4_if s_if ();

  axi4_rr_arbiter #(
    .AXI4_ADDRESS_WIDTH(32),
    .AXI4_DATA_WIDTH(32),
    .AXI4_ID_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m0(m_if[0]),
    .m1(m_if[1]),
    .s(s_if)
  );

  // Master-side drive and observe arrays
  logic [3:0]  arid [2], awid [2];
  logic [31:0] araddr [2], awaddr [2], wdata [2];
  logic [7:0]  arlen [2];
  logic        arvalid [2], rready [2], awvalid [2], wvalid [2], wlast [2], bready [2];
  logic        arready_o [2], rvalid_o [2], rlast_o [2], awready_o [2], wready_o [2], bvalid_o [2];
  logic [3:0]  rid_o [2], bid_o [2];
  logic [31:0] rdata_o [2];
  logic [1:0]  bresp_o [2];
  logic        rd_out [2] = '{1'b0, 1'b0};
  logic        wr_out [2] = '{1'b0, 1'b0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_m
    assign m_if[gi].ARID    = arid[gi];
    assign m_if[gi].ARADDR  = araddr[gi];
    assign m_if[gi].ARLEN   = arlen[gi];
    assign m_if[gi].ARSIZE  = 3'd2;
    assign m_if[gi].ARBURST = 2'b01;
    assign m_if[gi].ARVALID = arvalid[gi];
    assign m_if[gi].RREADY  = rready[gi];
    assign m_if[gi].AWID    = awid[gi];
    assign m_if[gi].AWADDR  = awaddr[gi];
    assign m_if[gi].AWLEN   = 8'd0;
    assign m_if[gi].AWSIZE  = 3'd2;
    assign m_if[gi].AWBURST = 2'b01;
    assign m_if[gi].AWVALID = awvalid[gi];
    assign m_if[gi].WDATA   = wdata[gi];
    assign m_if[gi].WSTRB   = 4'hF;
    assign m_if[gi].WLAST   = wlast[gi];
    assign m_if[gi].WVALID  = wvalid[gi];
    assign m_if[gi].BREADY  = bready[gi];
    assign arready_o[gi] = m_if[gi].ARREADY;
    assign rvalid_o[gi]  = m_if[gi].RVALID;
    assign rlast_o[gi]   = m_if[gi].RLAST;
    assign rid_o[gi]     = m_if[gi].RID;
    assign rdata_o[gi]   = m_if[gi].RDATA;
    assign awready_o[gi] = m_if[gi].AWREADY;
    assign wready_o[gi]  = m_if[gi].WREADY;
    assign bvalid_o[gi]  = m_if[gi].BVALID;
    assign bid_o[gi]     = m_if[gi].BID;
    assign bresp_o[gi]   = m_if[gi].BRESP;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: 'h%0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  function automatic logic [3:0] id_of(input int m);
    return (m == 0) ? 4'h1 : 4'h2;
  endfunction

  // Scoreboard queues
  logic [35:0] exp_r0 [$], exp_r1 [$];
  logic [5:0]  exp_b0 [$], exp_b1 [$];
  logic [31:0] exp_ar [$], exp_aw [$], exp_w [$];

  // Response to a master that has nothing outstanding is a routing error
  int viol = 0;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if ((rvalid_o[i] && !rd_out[i]) || (bvalid_o[i] && !wr_out[i])) viol <= viol + 1;
  end

  // Behavioural downstream slave
  int          aw_delay = 0;
  logic        w_before_aw = 1'b0;
  int          ar_gap = 0;
  int          last_rlast_cyc = 0;
  initial begin : slave
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, awv, rst_s, wl_s;
    logic [31:0] ar_addr_s, aw_addr_s, w_data_s, cur_addr;
    logic [7:0]  ar_len_s, cur_len, beat;
    logic [3:0]  ar_id_s, aw_id_s, cur_id, got_id;
    logic        aw_got, w_got;
    int          aw_cnt;
    aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; beat = 8'd0;
    cur_addr = '0; cur_len = '0; cur_id = '0; got_id = '0;
    s_if.ARREADY = 1'b1; s_if.RVALID = 1'b0; s_if.RLAST = 1'b0;
    s_if.RDATA = '0; s_if.RID = '0; s_if.RRESP = 2'b00;
    s_if.AWREADY = 1'b0; s_if.WREADY = 1'b1;
    s_if.BVALID = 1'b0; s_if.BID = '0; s_if.BRESP = 2'b00;
    forever begin
      @(negedge clk);
      rst_s = rst;
      ar_hs = s_if.ARVALID && s_if.ARREADY;
      r_hs  = s_if.RVALID && s_if.RREADY;
      aw_hs = s_if.AWVALID && s_if.AWREADY;
      w_hs  = s_if.WVALID && s_if.WREADY;
      b_hs  = s_if.BVALID && s_if.BREADY;
      awv   = s_if.AWVALID;
      ar_addr_s = s_if.ARADDR; ar_len_s = s_if.ARLEN; ar_id_s = s_if.ARID;
      aw_addr_s = s_if.AWADDR; aw_id_s = s_if.AWID;
      w_data_s  = s_if.WDATA;  wl_s = s_if.WLAST;
      if (r_hs && s_if.RLAST) last_rlast_cyc = cyc;
      if (ar_hs) ar_gap = cyc - last_rlast_cyc;
      @(posedge clk);
      #1;
      if (rst_s) begin
        s_if.RVALID = 1'b0; s_if.RLAST = 1'b0; s_if.AWREADY = 1'b0; s_if.BVALID = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0;
        continue;
      end
      if (r_hs) begin
        if (beat == cur_len) s_if.RVALID = 1'b0;
        else beat = beat + 8'd1;
      end
      if (ar_hs) begin
        check("s_ar_expected", exp_ar.size() > 0, 1'b1);
        if (exp_ar.size() > 0) check("s_araddr", ar_addr_s, exp_ar.pop_front());
        cur_addr = ar_addr_s; cur_len = ar_len_s; cur_id = ar_id_s; beat = 8'd0;
        s_if.RVALID = 1'b1;
      end
      s_if.RDATA = cur_addr + 32'(beat) * 4;
      s_if.RID   = cur_id;
      s_if.RLAST = (beat == cur_len);
      if (w_hs) begin
        check("s_w_expected", exp_w.size() > 0, 1'b1);
        if (exp_w.size() > 0) check("s_wdata", w_data_s, exp_w.pop_front());
        if (wl_s) begin
          w_got = 1'b1;
          if (!aw_got && !aw_hs) w_before_aw = 1'b1;
        end
      end
      if (aw_hs) begin
        check("s_aw_expected", exp_aw.size() > 0, 1'b1);
        if (exp_aw.size() > 0) check("s_awaddr", aw_addr_s, exp_aw.pop_front());
        aw_got = 1'b1; got_id = aw_id_s; s_if.AWREADY = 1'b0; aw_cnt = 0;
      end else if (awv && !s_if.AWREADY) begin
        aw_cnt++;
        if (aw_cnt > aw_delay) s_if.AWREADY = 1'b1;
      end
      if (b_hs) s_if.BVALID = 1'b0;
      if (aw_got && w_got) begin
        s_if.BVALID = 1'b1; s_if.BID = got_id; s_if.BRESP = 2'b00;
        aw_got = 1'b0; w_got = 1'b0;
      end
    end
  end

  task automatic rd_master(input int m, input logic [31:0] addr, input logic [7:0] len,
                           input bit chk_lat, output int cycles);
    int t0, k;
    logic [35:0] e;
    t0 = cyc;
    for (int i = 0; i <= int'(len); i++) begin
      e = {id_of(m), addr + 32'(i) * 4};
      if (m == 0) exp_r0.push_back(e); else exp_r1.push_back(e);
    end
    rd_out[m] = 1'b1;
    arid[m] = id_of(m); araddr[m] = addr; arlen[m] = len; arvalid[m] = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (arready_o[m]) break;
    end
    check($sformatf("ar_granted_m%0d", m), k < 300, 1'b1);
    if (chk_lat) begin
      check("ar_latency", k, 1);
      check("s_araddr_lat", s_if.ARADDR, addr);
    end
    @(posedge clk);
    #1;
    arvalid[m] = 1'b0;
    rready[m] = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      for (k = 0; k < 300; k++) begin
        @(negedge clk);
        if (rvalid_o[m]) break;
      end
      check($sformatf("r_beat_m%0d", m), k < 300, 1'b1);
      if (k >= 300) break;
      if (m == 0) e = (exp_r0.size() > 0) ? exp_r0.pop_front() : 'x;
      else        e = (exp_r1.size() > 0) ? exp_r1.pop_front() : 'x;
      check($sformatf("rid_rdata_m%0d", m), {rid_o[m], rdata_o[m]}, e);
      check($sformatf("rlast_m%0d", m), rlast_o[m], i == int'(len));
      @(posedge clk);
      #1;
    end
    rready[m] = 1'b0;
    rd_out[m] = 1'b0;
    cycles = cyc - t0;
  endtask

  task automatic wr_master(input int m, input logic [31:0] addr, input logic [31:0] data,
                           input bit w_first);
    logic aw_left, w_left, aw_hs, w_hs;
    logic [5:0] e;
    int k;
    if (m == 0) exp_b0.push_back({id_of(m), 2'b00}); else exp_b1.push_back({id_of(m), 2'b00});
    wr_out[m] = 1'b1;
    awid[m] = id_of(m); awaddr[m] = addr;
    wdata[m] = data; wlast[m] = 1'b1; wvalid[m] = 1'b1;
    if (w_first) begin
      repeat (2) @(posedge clk);
      #1;
    end
    awvalid[m] = 1'b1;
    aw_left = 1'b1; w_left = 1'b1;
    for (k = 0; k < 300 && (aw_left || w_left); k++) begin
      @(negedge clk);
      aw_hs = awvalid[m] && awready_o[m];
      w_hs  = wvalid[m] && wready_o[m];
      @(posedge clk);
      #1;
      if (aw_hs) begin awvalid[m] = 1'b0; aw_left = 1'b0; end
      if (w_hs)  begin wvalid[m]  = 1'b0; w_left  = 1'b0; end
    end
    check($sformatf("aw_w_done_m%0d", m), aw_left || w_left, 1'b0);
    bready[m] = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bvalid_o[m]) break;
    end
    check($sformatf("b_seen_m%0d", m), k < 300, 1'b1);
    if (m == 0) e = (exp_b0.size() > 0) ? exp_b0.pop_front() : 'x;
    else        e = (exp_b1.size() > 0) ? exp_b1.pop_front() : 'x;
    check($sformatf("bid_bresp_m%0d", m), {bid_o[m], bresp_o[m]}, e);
    @(posedge clk);
    #1;
    bready[m] = 1'b0;
    wr_out[m] = 1'b0;
  endtask

  function automatic logic [4:0] m_hs_vec(input int m);
    return {arready_o[m], rvalid_o[m], awready_o[m], wready_o[m], bvalid_o[m]};
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c_solo, c_conc, c_x, k;
    for (int i = 0; i < 2; i++) begin
      arid[i] = '0; araddr[i] = '0; arlen[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
      awid[i] = '0; awaddr[i] = '0; awvalid[i] = 1'b0; wdata[i] = '0; wlast[i] = 1'b0;
      wvalid[i] = 1'b0; bready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_m0_hs", m_hs_vec(0), 5'b0);
    check("reset_m1_hs", m_hs_vec(1), 5'b0);
    check("reset_s_valid_ready",
          {s_if.ARVALID, s_if.AWVALID, s_if.WVALID, s_if.RREADY, s_if.BREADY}, 5'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous reads after reset: m0 first, m1 after one idle cycle
    exp_ar.push_back(32'h0000_2000);
    exp_ar.push_back(32'h0000_2100);
    fork
      rd_master(0, 32'h0000_2000, 8'd1, 1'b0, c_x);
      rd_master(1, 32'h0000_2100, 8'd1, 1'b0, c_x);
    join
    check("idle_gap_between_reads", ar_gap, 2);

    // Round robin: both masters stream three reads each
    for (int i = 0; i < 3; i++) begin
      exp_ar.push_back(32'h0000_3000 + 32'(i) * 32'h10);
      exp_ar.push_back(32'h0000_3800 + 32'(i) * 32'h10);
    end
    fork
      for (int i = 0; i < 3; i++) rd_master(0, 32'h0000_3000 + 32'(i) * 32'h10, 8'd0, 1'b0, c_x);
      for (int j = 0; j < 3; j++) rd_master(1, 32'h0000_3800 + 32'(j) * 32'h10, 8'd0, 1'b0, c_x);
    join
    check("rr_ar_queue_drained", exp_ar.size(), 0);

    // Single 4-beat read from m0 with grant latency check
    exp_ar.push_back(32'h0000_1000);
    rd_master(0, 32'h0000_1000, 8'd3, 1'b1, c_solo);

    // m1 write with W presented before AW and a slow AWREADY
    aw_delay = 3;
    w_before_aw = 1'b0;
    exp_aw.push_back(32'h0000_4000);
    exp_w.push_back(32'hDEAD_BEEF);
    wr_master(1, 32'h0000_4000, 32'hDEAD_BEEF, 1'b1);
    check("w_before_aw", w_before_aw, 1'b1);
    aw_delay = 0;

    // Concurrent m0 read and m1 write; read timing must match the solo read
    exp_ar.push_back(32'h0000_5000);
    exp_aw.push_back(32'h0000_5800);
    exp_w.push_back(32'h1234_5678);
    fork
      rd_master(0, 32'h0000_5000, 8'd3, 1'b0, c_conc);
      wr_master(1, 32'h0000_5800, 32'h1234_5678, 1'b0);
    join
    check("read_no_stall_cycles", c_conc, c_solo);

    // m0 write leaves wr_prio pointing at m1 before the reset test
    exp_aw.push_back(32'h0000_5900);
    exp_w.push_back(32'hCAFE_0001);
    wr_master(0, 32'h0000_5900, 32'hCAFE_0001, 1'b0);

    // Reset during beat 2 of a 4-beat m0 read
    exp_ar.push_back(32'h0000_6000);
    rd_out[0] = 1'b1;
    arid[0] = id_of(0); araddr[0] = 32'h0000_6000; arlen[0] = 8'd3; arvalid[0] = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (arready_o[0]) break;
    end
    check("abort_ar_granted", k < 300, 1'b1);
    @(posedge clk);
    #1;
    arvalid[0] = 1'b0;
    rready[0] = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rvalid_o[0]) break;
    end
    check("abort_beat1", {rid_o[0], rdata_o[0]}, {id_of(0), 32'h0000_6000});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midburst_rst_m0_hs", m_hs_vec(0), 5'b0);
    check("midburst_rst_m1_hs", m_hs_vec(1), 5'b0);
    check("midburst_rst_s_valid_ready",
          {s_if.ARVALID, s_if.AWVALID, s_if.WVALID, s_if.RREADY, s_if.BREADY}, 5'b0);
    rst = 1'b0;
    rready[0] = 1'b0;
    rd_out[0] = 1'b0;
    exp_r0.delete();
    @(posedge clk);
    #1;

    // After reset both priorities must favour m0 on a tie
    exp_ar.push_back(32'h0000_7000);
    exp_ar.push_back(32'h0000_7100);
    fork
      rd_master(0, 32'h0000_7000, 8'd0, 1'b0, c_x);
      rd_master(1, 32'h0000_7100, 8'd0, 1'b0, c_x);
    join
    exp_aw.push_back(32'h0000_8000);
    exp_aw.push_back(32'h0000_8100);
    exp_w.push_back(32'hAAAA_0000);
    exp_w.push_back(32'hBBBB_1111);
    fork
      wr_master(0, 32'h0000_8000, 32'hAAAA_0000, 1'b0);
      wr_master(1, 32'h0000_8100, 32'hBBBB_1111, 1'b0);
    join

    repeat (3) @(posedge clk);
    #1;
    check("queues_drained", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
    check("no_misrouted_responses", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
